// File: rtl/count_pkg.sv
// Shared definitions for the count4 producer and its count_checker monitor.
`timescale 1ns/1ps
package count_pkg;
    // Default width of the free-running count bus.
    localparam int COUNT_WIDTH = 4;

    // Checker FSM encoding.
    localparam logic ST_UNLOCKED = 1'b0;
    localparam logic ST_LOCKED   = 1'b1;

    typedef enum logic {
        UNLOCKED = ST_UNLOCKED,
        LOCKED   = ST_LOCKED
    } chk_state_t;
endpackage

// File: rtl/sat_cnt.sv
// Parameterised-width saturating event counter; sticks at all-ones.
`timescale 1ns/1ps
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    // Count inc pulses, holding once every bit is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/count_checker.sv
// Monitor for a +1-per-cycle count stream: locks after SYNC_LEN good
// increments, flags and counts mismatches while locked, counts wraps.
`timescale 1ns/1ps
module count_checker
    import count_pkg::*;
#(
    parameter int WIDTH    = COUNT_WIDTH,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8,
    parameter int SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WIDTH-1:0]  in,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);
    // Run counter only needs to reach SYNC_LEN.
    localparam int GW = (SYNC_LEN < 1) ? 1 : $clog2(SYNC_LEN + 1);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] expv;
    logic             prev_v;
    logic [GW-1:0]    good;
    chk_state_t       state;
    logic             match;
    logic             mis_locked;

    // Expected next value wraps naturally through WIDTH-bit truncation.
    assign expv  = prev + WIDTH'(1);
    assign match = (in == expv);

    // A counted error is exactly a sampled mismatch while locked.
    assign mis_locked = en && prev_v && (state == LOCKED) && !match;

    sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mis_locked),
        .cnt   (err_cnt)
    );

    // Sequence tracking FSM with registered locked/err/wrap outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= UNLOCKED;
            prev     <= '0;
            prev_v   <= 1'b0;
            good     <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            err <= 1'b0;
            if (en) begin
                // Every sample, including a mismatching one, becomes the new
                // reference so resync can start on the very next cycle.
                prev   <= in;
                prev_v <= 1'b1;
                if (prev_v) begin
                    case (state)
                        UNLOCKED: begin
                            if (match) begin
                                if (good >= GW'(SYNC_LEN - 1)) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                    good   <= GW'(SYNC_LEN);
                                end else begin
                                    good <= good + GW'(1);
                                end
                            end else begin
                                good <= '0;
                            end
                        end
                        LOCKED: begin
                            if (match) begin
                                // Matching max->0 step is a genuine wrap.
                                if (&prev)
                                    wrap_cnt <= wrap_cnt + WRAP_W'(1);
                            end else begin
                                err    <= 1'b1;
                                state  <= UNLOCKED;
                                locked <= 1'b0;
                                good   <= '0;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: vector table, directed corner
// sequences and a randomized stream against a behavioural model.
`timescale 1ns/1ps
module tb_count_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] in = 4'd0;
    logic       locked, err, locked2, err2;
    logic [7:0] err_cnt, wrap_cnt, wrap_cnt2;
    logic [1:0] err_cnt2;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_prev, m_run, m_errs, m_wraps;
    bit m_pv, m_lock, m_err;

    typedef struct {
        bit en;
        int in;
        bit lock;
        bit err;
        int ecnt;
    } vec_t;
    vec_t vecs[12];

    count_checker dut (
        .clk(clk), .reset(reset), .en(en), .in(in),
        .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    count_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .in(in),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0;
        m_pv = 0; m_lock = 0; m_err = 0;
    endtask

    // Rules: lock after 2 consecutive +1 steps; while locked any non +1 step
    // is an error and drops lock; a good 15->0 step while locked is a wrap.
    task automatic model_step(input bit e, input int v);
        m_err = 0;
        if (e) begin
            if (m_pv) begin
                if (v == (m_prev + 1) % 16) begin
                    if (m_lock && m_prev == 15) m_wraps++;
                    m_run++;
                    if (m_run >= 2) m_lock = 1;
                end else begin
                    if (m_lock) begin
                        m_err = 1;
                        m_errs++;
                    end
                    m_lock = 0;
                    m_run = 0;
                end
            end
            m_prev = v;
            m_pv = 1;
        end
    endtask

    task automatic compare_all();
        chk("locked", locked, m_lock);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, imin(m_errs, 255));
        chk("wrap_cnt", wrap_cnt, m_wraps % 256);
        chk("locked_w2", locked2, m_lock);
        chk("err_w2", err2, m_err);
        chk("err_cnt_w2", err_cnt2, imin(m_errs, 3));
        chk("wrap_cnt_w2", wrap_cnt2, m_wraps % 256);
    endtask

    task automatic step(input bit e, input int v);
        @(negedge clk);
        en = e;
        in = v[3:0];
        @(posedge clk);
        #1;
        model_step(e, v);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        in = 4'd0;
        #100;
        model_reset();
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_wrap_cnt", wrap_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int g, pulses, cur, v;
        bit e;
        int w0;

        model_reset();

        // Clean stream: lock at 3rd edge, two wraps in 40 samples.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1, i % 16);
            if (i == 1) chk("clean_not_yet_locked", locked, 0);
            if (i == 2) chk("clean_lock_edge3", locked, 1);
            if (err) chk("clean_no_err", err, 0);
        end
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_wrap2", wrap_cnt, 2);

        // Single glitch while locked.
        do_reset();
        step(1, 2); step(1, 3); step(1, 4);
        step(1, 5); step(1, 6); step(1, 7);
        step(1, 9);
        chk("glitch_err", err, 1);
        chk("glitch_unlock", locked, 0);
        chk("glitch_err_cnt", err_cnt, 1);
        step(1, 10);
        chk("glitch_err_1cyc", err, 0);
        step(1, 11);
        chk("glitch_relock", locked, 1);

        // Upstream counter reset mid-run.
        step(1, 12); step(1, 13);
        w0 = wrap_cnt;
        step(1, 0);
        chk("upreset_err", err, 1);
        chk("upreset_err_cnt", err_cnt, 2);
        chk("upreset_no_wrap", wrap_cnt, w0);
        step(1, 1);
        step(1, 2);
        chk("upreset_relock", locked, 1);

        // en gaps hold all state.
        step(1, 3); step(1, 4);
        for (int i = 0; i < 3; i++) begin
            step(0, 4);
            chk("gap_locked", locked, 1);
            chk("gap_no_err", err, 0);
        end
        step(1, 5); step(1, 6);
        chk("gap_resume_locked", locked, 1);
        chk("gap_wrap_same", wrap_cnt, w0);

        // Vector table: lock, jump, gap, stall.
        vecs[0]  = '{1, 0,  0, 0, 0};
        vecs[1]  = '{1, 1,  0, 0, 0};
        vecs[2]  = '{1, 2,  1, 0, 0};
        vecs[3]  = '{1, 3,  1, 0, 0};
        vecs[4]  = '{1, 5,  0, 1, 1};
        vecs[5]  = '{1, 6,  0, 0, 1};
        vecs[6]  = '{1, 7,  1, 0, 1};
        vecs[7]  = '{0, 9,  1, 0, 1};
        vecs[8]  = '{1, 8,  1, 0, 1};
        vecs[9]  = '{1, 8,  0, 1, 2};
        vecs[10] = '{1, 9,  0, 0, 2};
        vecs[11] = '{1, 10, 1, 0, 2};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].en, vecs[i].in);
            chk($sformatf("vec%0d_locked", i), locked, vecs[i].lock);
            chk($sformatf("vec%0d_err", i), err, vecs[i].err);
            chk($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].ecnt);
        end

        // Saturation: 6 isolated errors, narrow counter sticks at 3.
        g = 10;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            g = (g + 5) % 16;
            step(1, g);
            if (err2) pulses++;
            g = (g + 1) % 16; step(1, g);
            if (err2) pulses++;
            g = (g + 1) % 16; step(1, g);
            if (err2) pulses++;
        end
        chk("sat_pulses", pulses, 6);
        chk("sat_err_cnt_w2", err_cnt2, 3);
        chk("sat_err_cnt_w8", err_cnt, 8);

        // Clean run to accumulate a wrap, then async reset between edges.
        for (int i = 1; i <= 20; i++) step(1, (g + i) % 16);
        chk("pre_async_locked", locked, 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_err_cnt", err_cnt, 0);
        chk("async_wrap_cnt", wrap_cnt, 0);
        chk("async_err", err, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1, 7);
        step(1, 8);
        chk("async_relock_not_yet", locked, 0);
        step(1, 9);
        chk("async_relock_edge3", locked, 1);

        // Randomized stream, mostly clean with occasional jumps and gaps.
        cur = 9;
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) < 8) v = (cur + 1) % 16;
            else v = $urandom_range(0, 15);
            step(e, v);
            if (e) cur = v;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/count_checker.md
# count_checker

Sequence checker that sits at the consuming end of the `count4` output bus. It samples the 4-bit count stream every clock and locks onto a +1-per-cycle sequence. It then flags every deviation, counts errors (saturating), and counts modulo wrap-arounds. It is used in-system and in benches as a self-checking monitor for any free-running up-counter.

## Interface
Parameters:
- `WIDTH`, 4: width of the observed count.
- `ERR_W`, 8: width of the error counter, which saturates.
- `WRAP_W`, 8: width of the wrap counter, which rolls over.
- `SYNC_LEN`, 2: number of consecutive good increments required to lock (≥1).

Ports:
- `clk`, input, 1: single clock; everything samples on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `en`, input, 1: sample qualifier; when 0, the checker ignores `in` and holds all state.
- `in`, input, WIDTH: observed count, e.g. the `count4` `out` output.
- `locked`, output, 1: high while tracking a valid sequence.
- `err`, output, 1: one-cycle pulse on a mismatch while locked.
- `err_cnt`, output, ERR_W: number of mismatches; saturates at all-ones.
- `wrap_cnt`, output, WRAP_W: number of max→0 transitions seen while locked; modulo 2^WRAP_W.

## Operation
- Internal state:
  - `prev`: last sampled value, WIDTH bits.
  - `prev_v`: prev-valid flag.
  - `good`: run counter, 0..SYNC_LEN.
  - FSM state, one of `UNLOCKED` or `LOCKED`.
- Expected value: `exp = prev + 1`, truncated to WIDTH bits, so 2^WIDTH−1 wraps to 0.
- On every sampled cycle (`en`=1), `prev <= in` and `prev_v <= 1`.
- `UNLOCKED` state (entered on reset):
  - If `prev_v`=0: load only; no comparison.
  - If `in == exp`: `good++`. When `good` reaches SYNC_LEN, go to `LOCKED` and set `locked`=1.
  - If `in != exp`: `good <= 0`. No `err`, and `err_cnt` does not change.
- `LOCKED` state:
  - If `in == exp`: stay `LOCKED`. If `prev` = 2^WIDTH−1 and `in`=0, then `wrap_cnt++`.
  - If `in != exp`: `err` pulses, `err_cnt++` unless it is all-ones, go to `UNLOCKED`, and `good <= 0`. The mismatching sample becomes the new `prev`, which makes resync possible on the next cycle.
- `en`=0: no state changes; `err` is 0 in that cycle. Gaps in `en` do not advance `exp`.
- A repeated value (stall) while `LOCKED` counts as a mismatch.
- A wrap with an error in the same sample (`prev`=max, `in`≠0): the error is counted and `wrap_cnt` does not change.

## Timing
- All outputs are registered.
- Reset values: `locked`=0, `err`=0, `err_cnt`=0, `wrap_cnt`=0. Internally, `prev`=0, `prev_v`=0, `good`=0, state `UNLOCKED`.
- Latency: a mismatching sample at edge k drives `err`=1 and the incremented `err_cnt` from edge k until edge k+1. `locked` falls at the same edge k.
- Lock latency after reset with a clean stream and continuous `en`:
  - First sample loads `prev`.
  - `locked` rises at the (SYNC_LEN+1)-th sampling edge. With the default SYNC_LEN=2, that is the third.
- Reset asserted mid-operation: outputs clear asynchronously, with no `err` pulse. After release, relock takes the full lock latency.
- `err` is never high on two consecutive cycles. After a mismatch the FSM is `UNLOCKED`, so the next sample cannot raise `err`.

## Structure
- Shared package/header `count_pkg`:
  - FSM state encoding localparams: `ST_UNLOCKED`=1'b0, `ST_LOCKED`=1'b1.
  - Default `WIDTH`=4, shared with `count4`.
- One natural sub-module, `sat_cnt`: a parameterised-width saturating incrementer with `inc` and async `reset`, used for `err_cnt`. `wrap_cnt` is a plain rolling register.
- The rest, in `count_checker`: compare logic, FSM, and `prev`/`good` registers.

## Test plan
- Clean stream: reset for 100 ns, then drive `in` = 0,1,2,… for 40 cycles with `en`=1.
  - Required: `locked` rises at the 3rd sampling edge.
  - Required: `err` never asserts and `err_cnt`=0.
  - Required: `wrap_cnt`=2 after the values 15→0 have been seen twice.
- Single glitch while locked: the sequence 5,6,7,9,10,11.
  - Required: `err` pulses for exactly one cycle at the sample of 9, `locked` falls, and `err_cnt`=1.
  - Required: `locked` rises again at the sample of 11.
- Upstream counter reset mid-run: 12,13,0,1,2.
  - Required: error at 0 and `err_cnt` increments by 1.
  - Required: no wrap is counted, and `locked` rises again at the sample of 2.
- `en` gaps: 3,4 (en=1), 4 held for 3 cycles (en=0), then 5,6 (en=1).
  - Required: no `err`, `locked` stays high, and `wrap_cnt` does not change.
- Saturation: ERR_W=2, with 6 isolated mismatches each separated by relock.
  - Required: `err_cnt` sticks at 3, and `err` still pulses 6 times.
- Async reset while locked: assert `reset` between clock edges.
  - Required: `locked`, `err_cnt`, and `wrap_cnt` go to 0 immediately, before the next edge.
  - Required: relock occurs 3 sampling edges after release.
